simplebus_target: RTL

- Responder end of the simplebus external bus: receives the 8-bit + parity request stream sent by microwatt's simplebus initiator and executes each request as a single Wishbone master cycle on a local peripheral bus.
- Returns the matching ack/error/read-data byte stream with parity on the response lines.
- Forwards a local interrupt onto the simplebus irq line.
- Lives in a companion chip/FPGA clocked from simplebus_clk, so one clock domain; no CDC.

---
 rtl/simplebus_target.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/simplebus_target.sv
`default_nettype none
// ============================================================================
// simplebus_target : simplebus responder, one Wishbone master cycle per frame
// Rev 1.0
// ============================================================================
module simplebus_target #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  bus_in,
    input  logic        parity_in,
    output logic [7:0]  bus_out,
    output logic        parity_out,
    input  logic        irq_in,
    output logic        irq_out,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        frame_err_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_WDATA     = 3'd2;
    localparam logic [2:0] S_WB        = 3'd3;
    localparam logic [2:0] S_RESP_HDR  = 3'd4;
    localparam logic [2:0] S_RESP_DATA = 3'd5;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  HDR_OK       = 8'h80;
    localparam logic [7:0]  HDR_ERR      = 8'hC0;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [1:0]  cnt;
    logic [15:0] wait_cnt;
    logic        cyc;
    logic        we;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdat;
    logic        par_ok;
    logic        to_hdr_ok;
    logic        to_hdr_err;

    assign par_ok    = ((^bus_in) == parity_in);
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = we;
    assign wbm_sel_o = sel;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = dat;

    always_comb begin
        state_n    = state;
        to_hdr_ok  = 1'b0;
        to_hdr_err = 1'b0;
        case (state)
            S_IDLE: begin
                // Bytes without the start bit are idle fill, parity is not checked.
                if (bus_in[7]) begin
                    if (par_ok && (bus_in[5:4] == 2'b00)) begin
                        state_n = S_ADDR;
                    end else begin
                        to_hdr_err = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (!par_ok) begin
                    to_hdr_err = 1'b1;
                end else if (cnt == 2'd3) begin
                    state_n = we ? S_WDATA : S_WB;
                end
            end
            S_WDATA: begin
                if (!par_ok) begin
                    to_hdr_err = 1'b1;
                end else if (cnt == 2'd3) begin
                    state_n = S_WB;
                end
            end
            S_WB: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (wbm_ack_i) begin
                    to_hdr_ok = 1'b1;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    to_hdr_err = 1'b1;
                end
            end
            S_RESP_HDR: begin
                state_n = (!err && !we) ? S_RESP_DATA : S_IDLE;
            end
            S_RESP_DATA: begin
                if (cnt == 2'd3) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (to_hdr_ok || to_hdr_err) begin
            state_n = S_RESP_HDR;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            wait_cnt    <= 16'd0;
            cyc         <= 1'b0;
            we          <= 1'b0;
            err         <= 1'b0;
            sel         <= 4'd0;
            adr         <= 32'd0;
            dat         <= 32'd0;
            rdat        <= 32'd0;
            bus_out     <= 8'h00;
            parity_out  <= 1'b0;
            irq_out     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            irq_out     <= irq_in;
            bus_out     <= 8'h00;
            parity_out  <= 1'b0;
            frame_err_o <= 1'b0;

            if (to_hdr_err) begin
                err         <= 1'b1;
                bus_out     <= HDR_ERR;
                parity_out  <= ^HDR_ERR;
                frame_err_o <= 1'b1;
            end
            if (to_hdr_ok) begin
                err        <= 1'b0;
                bus_out    <= HDR_OK;
                parity_out <= ^HDR_OK;
            end

            if ((state_n == S_WB) && (state != S_WB)) begin
                cyc      <= 1'b1;
                wait_cnt <= 16'd0;
            end else if ((state == S_WB) && (state_n != S_WB)) begin
                cyc <= 1'b0;
            end else if (state == S_WB) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (state_n == S_ADDR) begin
                        we  <= bus_in[6];
                        sel <= bus_in[3:0];
                        cnt <= 2'd0;
                    end
                end
                S_ADDR: begin
                    // LSB-first bytes shift in from the top; cnt wraps to 0 for WDATA.
                    if (par_ok) begin
                        adr <= {bus_in, adr[31:8]};
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WDATA: begin
                    if (par_ok) begin
                        dat <= {bus_in, dat[31:8]};
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WB: begin
                    if (wbm_ack_i && !we) begin
                        rdat <= wbm_dat_i;
                    end
                end
                S_RESP_HDR: begin
                    if (state_n == S_RESP_DATA) begin
                        bus_out    <= rdat[7:0];
                        parity_out <= ^rdat[7:0];
                        rdat       <= rdat >> 8;
                        cnt        <= 2'd0;
                    end
                end
                S_RESP_DATA: begin
                    cnt <= cnt + 2'd1;
                    if (cnt != 2'd3) begin
                        bus_out    <= rdat[7:0];
                        parity_out <= ^rdat[7:0];
                        rdat       <= rdat >> 8;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
